// File: rtl/hazard_ctrl_param_if.sv
// hazard_ctrl_param_if
// Bundles the pipeline-to-hazard-controller signals.
//   master : pipeline side; drives fetch/data handshakes and decode info,
//            receives latch codes, PC enable, forwarding selects and counters.
//   slave  : hazard controller side (mirror of master).
// Signals: ihit, dhit, dmem_req, dec_valid, dec_rs, dec_rt, dec_uses_rt,
//          dec_wen, dec_wsel, dec_is_load, flush_req (pipeline -> controller);
//          pc_wen, latch_state, fwd_rs, fwd_rt, hz_stall, perf_stall,
//          perf_flush, perf_memwait (controller -> pipeline).
interface hazard_ctrl_param_if #(
  parameter int NLATCH = 4,
  parameter int NREGS  = 32
);
  localparam int REG_W = $clog2(NREGS);
  localparam int FWD_W = $clog2(NLATCH);

  logic                  ihit;
  logic                  dhit;
  logic                  dmem_req;
  logic                  dec_valid;
  logic [REG_W-1:0]      dec_rs;
  logic [REG_W-1:0]      dec_rt;
  logic                  dec_uses_rt;
  logic                  dec_wen;
  logic [REG_W-1:0]      dec_wsel;
  logic                  dec_is_load;
  logic                  flush_req;
  logic                  pc_wen;
  logic [2*NLATCH-1:0]   latch_state;
  logic [FWD_W-1:0]      fwd_rs;
  logic [FWD_W-1:0]      fwd_rt;
  logic                  hz_stall;
  logic [31:0]           perf_stall;
  logic [31:0]           perf_flush;
  logic [31:0]           perf_memwait;

  modport master (
    output ihit, dhit, dmem_req, dec_valid, dec_rs, dec_rt, dec_uses_rt,
           dec_wen, dec_wsel, dec_is_load, flush_req,
    input  pc_wen, latch_state, fwd_rs, fwd_rt, hz_stall,
           perf_stall, perf_flush, perf_memwait
  );

  modport slave (
    input  ihit, dhit, dmem_req, dec_valid, dec_rs, dec_rt, dec_uses_rt,
           dec_wen, dec_wsel, dec_is_load, flush_req,
    output pc_wen, latch_state, fwd_rs, fwd_rt, hz_stall,
           perf_stall, perf_flush, perf_memwait
  );
endinterface

// File: rtl/hazard_ctrl_param.sv
// hazard_ctrl_param
// Hazard controller for an NLATCH-latch in-order pipeline. Tracks in-flight
// destinations (entry k = instruction after latch k), detects decode RAW
// hazards, selects forwarding sources, and arbitrates flush / memory waits.
// Ports:
//   CLK   : clock, rising edge
//   nRST  : asynchronous active-low reset
//   ctl   : hazard_ctrl_param_if.slave bundle (see interface header)
// Optional: define HAZARD_PERF_EN to enable the 32-bit saturating
// perf_stall / perf_flush / perf_memwait counters; otherwise they read 0.
module hazard_ctrl_param #(
  parameter int NLATCH      = 4,
  parameter int NREGS       = 32,
  parameter int ALU_READY   = 1,
  parameter int LOAD_READY  = 2,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic                 CLK,
  input  logic                 nRST,
  hazard_ctrl_param_if.slave   ctl
);
  localparam int REG_W = $clog2(NREGS);
  localparam int FWD_W = $clog2(NLATCH);
  localparam int unsigned AR = ALU_READY;
  localparam int unsigned LR = LOAD_READY;
  localparam int unsigned FD = FLUSH_DEPTH;

  localparam logic [1:0] LS_ENABLE = 2'b00;
  localparam logic [1:0] LS_STALL  = 2'b01;
  localparam logic [1:0] LS_NOP    = 2'b10;

  logic [NLATCH-1:1] v_q, v_d;
  logic [NLATCH-1:1] ld_q, ld_d;
  logic [REG_W-1:0]  w_q [NLATCH-1:1];
  logic [REG_W-1:0]  w_d [NLATCH-1:1];

  logic              rs_haz, rt_haz, rs_done, rt_done;
  logic [FWD_W-1:0]  rs_fwd, rt_fwd;
  logic              mem_wait, hazard, stall, pc_en;
  logic [1:0]        code [NLATCH];
  logic [2*NLATCH-1:0] ls;

  assign mem_wait = ctl.dmem_req && !ctl.dhit;

  // Scan youngest to oldest; the first match decides. A match that is not
  // yet ready is a hazard and leaves the forward select at the register file.
  always_comb begin
    rs_haz  = 1'b0;
    rt_haz  = 1'b0;
    rs_done = 1'b0;
    rt_done = 1'b0;
    rs_fwd  = '0;
    rt_fwd  = '0;
    for (int unsigned k = 1; k < NLATCH; k++) begin
      if (!rs_done && v_q[k] && w_q[k] == ctl.dec_rs && ctl.dec_rs != '0) begin
        rs_done = 1'b1;
        if (k < (ld_q[k] ? LR : AR)) rs_haz = 1'b1;
        else                         rs_fwd = FWD_W'(k);
      end
      if (!rt_done && ctl.dec_uses_rt && v_q[k] && w_q[k] == ctl.dec_rt &&
          ctl.dec_rt != '0) begin
        rt_done = 1'b1;
        if (k < (ld_q[k] ? LR : AR)) rt_haz = 1'b1;
        else                         rt_fwd = FWD_W'(k);
      end
    end
  end

  assign hazard = ctl.dec_valid && (rs_haz || rt_haz);

  always_comb begin
    pc_en = 1'b1;
    stall = 1'b0;
    for (int unsigned k = 0; k < NLATCH; k++) code[k] = LS_ENABLE;
    if (mem_wait) begin
      pc_en = 1'b0;
      for (int unsigned k = 0; k < NLATCH; k++) code[k] = LS_STALL;
    end else if (ctl.flush_req) begin
      for (int unsigned k = 0; k < NLATCH; k++)
        if (k < FD) code[k] = LS_NOP;
    end else if (hazard) begin
      pc_en   = 1'b0;
      stall   = 1'b1;
      code[0] = LS_STALL;
      code[1] = LS_NOP;
    end else if (!ctl.ihit) begin
      pc_en   = 1'b0;
      code[0] = LS_NOP;
    end
  end

  always_comb begin
    ls = '0;
    for (int unsigned k = 0; k < NLATCH; k++) ls[2*k +: 2] = code[k];
  end

  assign ctl.latch_state = ls;
  assign ctl.pc_wen      = pc_en;
  assign ctl.hz_stall    = stall;
  assign ctl.fwd_rs      = (stall || ctl.flush_req || mem_wait) ? '0 : rs_fwd;
  assign ctl.fwd_rt      = (stall || ctl.flush_req || mem_wait) ? '0 : rt_fwd;

  // Tracker entry k follows the code of latch k.
  always_comb begin
    v_d  = v_q;
    ld_d = ld_q;
    w_d  = w_q;
    case (code[1])
      LS_ENABLE: begin
        v_d[1]  = ctl.dec_valid && ctl.dec_wen && ctl.dec_wsel != '0;
        w_d[1]  = ctl.dec_wsel;
        ld_d[1] = ctl.dec_is_load;
      end
      LS_NOP:  v_d[1] = 1'b0;
      default: ;
    endcase
    for (int unsigned k = 2; k < NLATCH; k++) begin
      case (code[k])
        LS_ENABLE: begin
          v_d[k]  = v_q[k-1];
          w_d[k]  = w_q[k-1];
          ld_d[k] = ld_q[k-1];
        end
        LS_NOP:  v_d[k] = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      v_q  <= '0;
      ld_q <= '0;
      for (int unsigned k = 1; k < NLATCH; k++) w_q[k] <= '0;
    end else begin
      v_q  <= v_d;
      ld_q <= ld_d;
      w_q  <= w_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] pst_q, pfl_q, pmw_q;
  logic        flush_taken;

  assign flush_taken = ctl.flush_req && !mem_wait;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pst_q <= '0;
      pfl_q <= '0;
      pmw_q <= '0;
    end else begin
      if (stall && pst_q != '1)       pst_q <= pst_q + 32'd1;
      if (flush_taken && pfl_q != '1) pfl_q <= pfl_q + 32'd1;
      if (mem_wait && pmw_q != '1)    pmw_q <= pmw_q + 32'd1;
    end
  end

  assign ctl.perf_stall   = pst_q;
  assign ctl.perf_flush   = pfl_q;
  assign ctl.perf_memwait = pmw_q;
`else
  assign ctl.perf_stall   = '0;
  assign ctl.perf_flush   = '0;
  assign ctl.perf_memwait = '0;
`endif
endmodule
